// File: rtl/fp_multiplier_pipe.sv
// fp_multiplier_pipe: 3-stage IEEE-754-style multiplier, round-to-nearest-even, flush-to-zero, valid/ready
module fp_multiplier_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic [3:0]             out_flags
);
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam int LZW = $clog2(PW + 1);
  localparam int XW = EW + LZW + 1;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  logic adv;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic a_ez, b_ez, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic v1, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [EW-1:0] s1_exp;
  logic [MAN_W:0] s1_sa, s1_sb;
  logic v2, s2_sign, s2_nan, s2_inf, s2_zero;
  logic [EW-1:0] s2_exp;
  logic [PW-1:0] s2_p;
  logic [LZW-1:0] lz;
  logic [PW-2:0] nrm;
  logic [MAN_W-1:0] frac;
  logic guard, sticky, inc;
  logic [MAN_W:0] rnd;
  logic [XW-1:0] exp_f;
  logic ovf, unf;
  logic [EXP_W+MAN_W:0] res;
  logic [3:0] flags;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign ea = in_a[EXP_W+MAN_W-1:MAN_W];
  assign eb = in_b[EXP_W+MAN_W-1:MAN_W];
  assign ma = in_a[MAN_W-1:0];
  assign mb = in_b[MAN_W-1:0];
  assign a_ez = ea == '0;
  assign b_ez = eb == '0;
  assign a_nan = ea == EMAX && ma != '0;
  assign b_nan = eb == EMAX && mb != '0;
  assign a_inf = ea == EMAX && ma == '0;
  assign b_inf = eb == EMAX && mb == '0;
  assign a_zero = a_ez && ma == '0;
  assign b_zero = b_ez && mb == '0;
  // Stage valids and the output register; everything advances together on adv
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_res <= '0;
      out_flags <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      if (v2) begin
        out_res <= res;
        out_flags <= flags;
      end
    end
  end
  // Unpack and multiply data stages; subnormals use exponent 1 with hidden bit 0
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= in_a[EXP_W+MAN_W] ^ in_b[EXP_W+MAN_W];
      s1_nan <= a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
      s1_inf <= a_inf || b_inf;
      s1_zero <= a_zero || b_zero;
      s1_exp <= EW'(ea | EXP_W'(a_ez)) + EW'(eb | EXP_W'(b_ez)) - BIAS;
      s1_sa <= {!a_ez, ma};
      s1_sb <= {!b_ez, mb};
      s2_sign <= s1_sign;
      s2_nan <= s1_nan;
      s2_inf <= s1_inf;
      s2_zero <= s1_zero;
      s2_exp <= s1_exp;
      s2_p <= PW'(s1_sa) * PW'(s1_sb);
    end
  end
  // Leading-zero count of the full product; the highest set bit wins
  always_comb begin
    lz = LZW'(PW);
    for (int i = 0; i < PW; i++)
      if (s2_p[i]) lz = LZW'(PW - 1 - i);
  end
  assign nrm = (PW-1)'(s2_p << lz);
  assign frac = nrm[PW-2:MAN_W+1];
  assign guard = nrm[MAN_W];
  assign sticky = |nrm[MAN_W-1:0];
  assign inc = guard && (sticky || frac[0]);
  assign rnd = {1'b0, frac} + (MAN_W+1)'(inc);
  assign exp_f = {{(XW-EW){s2_exp[EW-1]}}, s2_exp} + XW'(1) - XW'(lz) + XW'(rnd[MAN_W]);
  assign ovf = !exp_f[XW-1] && exp_f >= XW'(EMAX);
  assign unf = exp_f[XW-1] || exp_f == '0;
  assign res = s2_nan ? {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}} :
               (s2_inf || (!s2_zero && ovf)) ? {s2_sign, EMAX, {MAN_W{1'b0}}} :
               (s2_zero || unf) ? {s2_sign, {(EXP_W+MAN_W){1'b0}}} :
               {s2_sign, exp_f[EXP_W-1:0], rnd[MAN_W-1:0]};
  assign flags = s2_nan ? 4'b1000 :
                 (s2_inf || s2_zero) ? 4'b0000 :
                 {1'b0, ovf, unf, guard || sticky || ovf || unf};
endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// tb_fp_multiplier_pipe: directed checks of the pipelined FP multiplier at two widths
module tb_fp_multiplier_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0] out_flags;
  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [15:0] s_in_a, s_in_b, s_out_res;
  logic [3:0] s_out_flags;
  int total = 0, bad = 0;
  fp_multiplier_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags)
  );
  fp_multiplier_pipe #(.EXP_W(5), .MAN_W(10)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_res(s_out_res), .out_flags(s_out_flags)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input logic [3:0] f);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, ".lat2"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".res"}, 64'(out_res), 64'(r));
    chk({tag, ".flags"}, 64'(out_flags), 64'(f));
  endtask
  task automatic sop(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] r, input logic [3:0] f);
    @(negedge clk);
    s_in_valid = 1'b1; s_in_a = a; s_in_b = b;
    @(negedge clk);
    s_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, ".valid"}, 64'(s_out_valid), 64'd1);
    chk({tag, ".res"}, 64'(s_out_res), 64'(r));
    chk({tag, ".flags"}, 64'(s_out_flags), 64'(f));
  endtask
  initial begin
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic [31:0] sr [8];
    logic [3:0] sf [8];
    logic [31:0] rpat;
    logic [36:0] hv;
    logic held;
    int ni, no, extra;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_in_a = '0; s_in_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.out_res", 64'(out_res), 64'd0);
    chk("reset.out_flags", 64'(out_flags), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    op("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    op("round_sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    op("tie_round_up", 32'h3F800001, 32'h40400000, 32'h40400002, 4'b0001);
    op("tie_keep_even", 32'h3F800003, 32'h40400000, 32'h40400004, 4'b0001);
    op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    op("ninf_x_2", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    op("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    op("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    op("subnorm_x_2", 32'h00400000, 32'h40000000, 32'h00800000, 4'b0000);
    op("sub_x_sub", 32'h00000001, 32'h80000001, 32'h80000000, 4'b0011);
    op("zero_x_neg", 32'hC0000000, 32'h00000000, 32'h80000000, 4'b0000);
    op("inf_x_ninf", 32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000);
    sa = '{32'h3F800000, 32'h40000000, 32'hC0000000, 32'h40400000, 32'h3FC00000, 32'h41200000, 32'h3F800001, 32'h00000000};
    sb = '{32'h40400000, 32'h40000000, 32'h3F000000, 32'h40400000, 32'h3FC00000, 32'hC1200000, 32'h3F800001, 32'hC0000000};
    sr = '{32'h40400000, 32'h40800000, 32'hBF800000, 32'h41100000, 32'h40100000, 32'hC2C80000, 32'h3F800002, 32'h80000000};
    sf = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    rpat = 32'b1011_0010_1100_0110_1001_1101_0011_0100;
    ni = 0; no = 0; held = 1'b0; hv = '0;
    for (int cyc = 0; cyc < 300 && no < 8; cyc++) begin
      @(negedge clk);
      if (held) chk("stall_hold", 64'({out_valid, out_flags, out_res}), 64'(hv));
      in_valid = ni < 8;
      in_a = ni < 8 ? sa[ni] : 32'h0;
      in_b = ni < 8 ? sb[ni] : 32'h0;
      out_ready = rpat[cyc % 32];
      #1;
      held = out_valid && !out_ready;
      hv = {out_valid, out_flags, out_res};
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d.res", no), 64'(out_res), 64'(sr[no]));
        chk($sformatf("stream%0d.flags", no), 64'(out_flags), 64'(sf[no]));
        no++;
      end
      if (in_valid && in_ready) ni++;
    end
    chk("stream_count", 64'(no), 64'd8);
    in_valid = 1'b0; out_ready = 1'b1; extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stream_no_dup", 64'(extra), 64'd0);
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40000000;
    @(negedge clk);
    in_a = 32'h40400000; in_b = 32'h40400000;
    @(negedge clk);
    in_a = 32'h3FC00000; in_b = 32'h3FC00000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst.valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_res", 64'(out_res), 64'd0);
    chk("rst.out_flags", 64'(out_flags), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("rst.no_stale", 64'(extra), 64'd0);
    sop("half_1p5x2", 16'h3E00, 16'h4000, 16'h4200, 4'b0000);
    sop("half_ovf", 16'h7800, 16'h4000, 16'h7C00, 4'b0101);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_multiplier_pipe.md
# fp_multiplier_pipe

Pipelined, parametrised IEEE-754-style floating-point multiplier with a valid/ready handshake on both sides. Generalises the existing combinational single-precision multiplier:
- configurable exponent/mantissa widths;
- round-to-nearest-even;
- special-value handling (NaN, Inf, zero);
- exception flags;
- fixed 3-cycle latency with backpressure.

It sits in the ALU datapath between operand issue and result writeback.

## Interface
- EXP_W, 8, exponent field width (≥4)
- MAN_W, 23, stored mantissa field width (≥4); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  W  operand A {sign, exp, man}
- in_b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_res  out  W  product
- out_flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- Bias = 2^(EXP_W-1)-1. EMAX = 2^EXP_W-1 (all ones).
- Input classification per operand:
  - exp==EMAX, man!=0: NaN.
  - exp==EMAX, man==0: Inf.
  - exp==0, man==0: zero.
  - exp==0, man!=0: subnormal, treated as effective exp 1 with hidden bit 0.
  - Otherwise: normal, hidden bit 1.
- Sign = sign_a XOR sign_b for all non-NaN results.
- Stage 1 (unpack):
  - Classify both operands.
  - Compute the exponent sum ea+eb-bias as a signed (EXP_W+2)-bit value.
  - Form the (MAN_W+1)-bit significands.
- Stage 2 (multiply): full 2(MAN_W+1)-bit significand product.
- Stage 3 (normalise/round/pack):
  - Normalise:
    - If product MSB is set: shift right 1, exp+1.
    - Otherwise: shift left by the leading-zero count to bit 2·MAN_W, exp−lzc.
  - Round: keep MAN_W fraction bits; guard = next bit; sticky = OR of the rest. Round-to-nearest-even: increment when guard & (sticky | lsb). A rounding carry-out renormalises with exp+1.
  - inexact = guard | sticky.
  - Overflow: final exp ≥ EMAX → signed Inf; set overflow and inexact.
  - Underflow: final exp < 1 → signed zero (flush-to-zero, no subnormal outputs); set underflow and inexact.
- Special values (override the arithmetic result):
  - Any NaN operand, or Inf×zero → canonical qNaN: sign 0, exp EMAX, man MSB 1, rest 0. invalid=1; all other flags 0.
  - Inf × (normal/subnormal/Inf) → signed Inf, flags 0.
  - zero × finite → signed zero, flags 0.
  - Subnormal×subnormal follows the normal path and underflows to zero.

## Timing
- Latency: result appears exactly 3 cycles after acceptance when not stalled.
- Throughput: 1 result/cycle.
- Pipeline advance: `adv = !out_valid | out_ready`. All three stages advance together on adv; all hold on !adv.
- in_ready = adv (combinational from out_ready and out_valid).
- An operand pair is accepted on a rising edge where in_valid & in_ready.
- Output stability: while out_valid & !out_ready, out_res and out_flags are held stable.
- Bubbles: bubbles propagate as valid=0 stages. No reordering; results leave in acceptance order.
- Reset:
  - Clears all stage valid bits, out_valid=0, out_res=0, out_flags=0.
  - Data registers need no reset.
  - Operands in flight at reset are discarded.
  - in_ready=1 in the first cycle after reset.
- Simultaneous in_valid and out_ready while full: the output handshake and input acceptance both complete on the same edge.

## Test plan
- Default widths:
  - 0x3FC00000 × 0x40000000 (1.5×2.0) → 0x40400000, flags 0000.
  - Issue at cycle t → out_valid at t+3.
- Rounding: 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000, invalid=1.
- Range:
  - 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1, inexact=1.
  - 0x00800000 × 0x3F000000 → 0x00000000, underflow=1, inexact=1.
- Backpressure:
  - Stream 8 random pairs with out_ready toggling pseudo-randomly.
  - Required: every result matches the reference model, in order.
  - Required: no result lost or duplicated.
  - Required: out_res is stable while stalled.
- Reset mid-stream with 3 ops in flight:
  - out_valid=0 the cycle after reset.
  - No stale result emerges.
  - Rerun with EXP_W=5, MAN_W=10: 0x3E00 × 0x4000 → 0x4200.
